// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Error code bits presented alongside each byte.
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_byte_receiver_if.sv
// Bundle between the PS/2 pins / mouse master and the byte receiver.
interface ps2_byte_receiver_if;
  import ps2_pkg::*;

  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  // Master side: drives the pins and the enable, consumes received bytes.
  modport master (
    output CLK_MOUSE_IN,
    output DATA_MOUSE_IN,
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  // Slave side: the receiver itself.
  modport slave (
    input  CLK_MOUSE_IN,
    input  DATA_MOUSE_IN,
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes the raw PS/2 clock and data pins, deglitches the clock and
// emits a one-cycle pulse on each accepted falling edge of the clock.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLK_RAW,
  input  logic DATA_RAW,
  output logic data_sync,
  output logic fe
);
  import ps2_pkg::*;

  localparam int CW = $clog2(FILTER_LEN + 1);

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    raw_lines;
  logic [1:0]    meta_reg;
  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          clk_filt_reg;
  logic          fe_reg;

  assign raw_lines = {DATA_RAW, CLK_RAW};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      // Two-flop synchronizer; resets to the idle-high bus level.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= raw_lines[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  // Accept a new clock level only after it has been stable for FILTER_LEN cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg      <= '0;
      clk_filt_reg <= 1'b1;
      fe_reg       <= 1'b0;
    end else begin
      fe_reg <= 1'b0;
      if (sync_reg[0] != clk_filt_reg) begin
        if (cnt_reg == CW'(FILTER_LEN - 1)) begin
          clk_filt_reg <= sync_reg[0];
          cnt_reg      <= '0;
          fe_reg       <= ~sync_reg[0];
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign data_sync = sync_reg[1];
  assign fe        = fe_reg;

endmodule

// File: rtl/ps2_byte_receiver.sv
// Host-side PS/2 byte receiver: deframes 11-bit device frames into a byte,
// a 2-bit error code and a one-cycle ready strobe.
module ps2_byte_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ps2_byte_receiver_if.slave   bus
);
  import ps2_pkg::*;

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic          data_sync;
  logic          fe;

  state_t        state_reg,      state_next;
  logic [2:0]    bit_cnt_reg,    bit_cnt_next;
  logic [7:0]    shift_reg,      shift_next;
  logic          parity_err_reg, parity_err_next;
  logic [TW-1:0] timeout_reg,    timeout_next;
  logic [7:0]    byte_read_reg,  byte_read_next;
  logic [1:0]    byte_err_reg,   byte_err_next;
  logic          byte_ready_reg, byte_ready_next;
  logic          stop_err;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLK_RAW   (bus.CLK_MOUSE_IN),
    .DATA_RAW  (bus.DATA_MOUSE_IN),
    .data_sync (data_sync),
    .fe        (fe)
  );

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_err_reg <= 1'b0;
      timeout_reg    <= '0;
      byte_read_reg  <= '0;
      byte_err_reg   <= '0;
      byte_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_err_reg <= parity_err_next;
      timeout_reg    <= timeout_next;
      byte_read_reg  <= byte_read_next;
      byte_err_reg   <= byte_err_next;
      byte_ready_reg <= byte_ready_next;
    end
  end

  // Frame sequencing; outputs are loaded on the stop-bit edge so they are
  // valid together with the strobe during the DONE cycle.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_err_next = parity_err_reg;
    timeout_next    = timeout_reg;
    byte_read_next  = byte_read_reg;
    byte_err_next   = byte_err_reg;
    byte_ready_next = 1'b0;
    stop_err        = ~data_sync;

    case (state_reg)
      IDLE: begin
        timeout_next = '0;
        if (fe && bus.READ_ENABLE && !data_sync) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA, PARITY, STOP: begin
        if (fe) begin
          timeout_next = '0;
          if (state_reg == DATA) begin
            shift_next[bit_cnt_reg] = data_sync;
            if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
              state_next = PARITY;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else if (state_reg == PARITY) begin
            parity_err_next = ~(^{shift_reg, data_sync});
            state_next      = STOP;
          end else begin
            byte_read_next  = shift_reg;
            byte_err_next   = (parity_err_reg ? ERR_PARITY : 2'b00) |
                              (stop_err       ? ERR_STOP   : 2'b00);
            byte_ready_next = 1'b1;
            state_next      = DONE;
          end
        end else if (timeout_reg == TW'(TIMEOUT_CYCLES)) begin
          state_next   = IDLE;
          timeout_next = '0;
        end else begin
          timeout_next = timeout_reg + TW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.BYTE_READ       = byte_read_reg;
  assign bus.BYTE_ERROR_CODE = byte_err_reg;
  assign bus.BYTE_READY      = byte_ready_reg;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed self-checking bench for ps2_byte_receiver (time-scaled PS/2 bus).
`timescale 1ns/1ps
module tb_ps2_byte_receiver;
  localparam int FILTER    = 8;
  localparam int TIMEOUT   = 500;
  localparam int HALF      = 40;   // half PS/2 bit period in CLK cycles
  localparam int LATENCY   = 3 + FILTER;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   ready_cnt = 0;
  int   ready_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] last_code = 2'b00;

  ps2_byte_receiver_if bif ();

  ps2_byte_receiver #(
    .FILTER_LEN     (FILTER),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bif)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every delivered byte, one line per transaction.
  always @(negedge CLK) begin
    if (bif.BYTE_READY === 1'b1) begin
      ready_cnt = ready_cnt + 1;
      ready_cyc = cyc;
      last_byte = bif.BYTE_READ;
      last_code = bif.BYTE_ERROR_CODE;
      $display("byte 0x%02h code %b at cycle %0d", bif.BYTE_READ, bif.BYTE_ERROR_CODE, cyc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic par,
                                     input logic stp, input logic start);
    return {stp, par, d, start};
  endfunction

  // Drive frame bits [first, last] LSB first; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] frame, input int first, input int last,
                           input bit glitch);
    for (int i = first; i <= last; i++) begin
      bif.DATA_MOUSE_IN = frame[i];
      wait_cycles(HALF / 2);
      if (glitch) begin
        bif.CLK_MOUSE_IN = 1'b0;
        wait_cycles(3);
        bif.CLK_MOUSE_IN = 1'b1;
        wait_cycles(HALF / 2 - 3);
      end else begin
        wait_cycles(HALF / 2);
      end
      bif.CLK_MOUSE_IN = 1'b0;
      fall_cyc = cyc;
      wait_cycles(HALF);
      bif.CLK_MOUSE_IN = 1'b1;
    end
    bif.DATA_MOUSE_IN = 1'b1;
  endtask

  task automatic expect_byte(input string name, input int rc0,
                             input logic [7:0] b, input logic [1:0] c);
    checks++;
    if (ready_cnt !== rc0 + 1) begin
      errors++;
      $display("FAIL %s_count: got %0d strobes, required 1", name, ready_cnt - rc0);
    end
    checks++;
    if (last_byte !== b) begin
      errors++;
      $display("FAIL %s_byte: got %02h, required %02h", name, last_byte, b);
    end
    checks++;
    if (last_code !== c) begin
      errors++;
      $display("FAIL %s_code: got %b, required %b", name, last_code, c);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bif.BYTE_READ !== 8'h00 || bif.BYTE_ERROR_CODE !== 2'b00 || bif.BYTE_READY !== 1'b0) begin
      errors++;
      $display("FAIL %s: got byte=%02h code=%b ready=%b, required 00/00/0", name,
               bif.BYTE_READ, bif.BYTE_ERROR_CODE, bif.BYTE_READY);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    wait_cycles(5);
    check_outputs_zero("reset_state");
    RESET = 1'b0;
    wait_cycles(5);
    check_outputs_zero("after_reset_release");
  endtask

  task automatic test_basic();
    int rc0;
    rc0 = ready_cnt;
    send_bits(mk(8'hFA, 1'b1, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("fa", rc0, 8'hFA, 2'b00);
    checks++;
    if (ready_cyc - fall_cyc !== LATENCY) begin
      errors++;
      $display("FAIL fa_latency: got %0d cycles, required %0d", ready_cyc - fall_cyc, LATENCY);
    end
    rc0 = ready_cnt;
    send_bits(mk(8'hAA, 1'b1, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("aa", rc0, 8'hAA, 2'b00);
    rc0 = ready_cnt;
    send_bits(mk(8'h00, 1'b1, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("zero", rc0, 8'h00, 2'b00);
  endtask

  task automatic test_errors();
    int rc0;
    rc0 = ready_cnt;
    send_bits(mk(8'hAA, 1'b0, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("parity_err", rc0, 8'hAA, 2'b01);
    rc0 = ready_cnt;
    send_bits(mk(8'h00, 1'b1, 1'b0, 1'b0), 0, 10, 1'b0);
    expect_byte("stop_err", rc0, 8'h00, 2'b10);
  endtask

  task automatic test_timeout();
    int rc0;
    rc0 = ready_cnt;
    send_bits(mk(8'h3C, 1'b1, 1'b1, 1'b0), 0, 4, 1'b0);
    wait_cycles(TIMEOUT + TIMEOUT / 5);
    checks++;
    if (ready_cnt !== rc0) begin
      errors++;
      $display("FAIL timeout_no_ready: got %0d strobes, required 0", ready_cnt - rc0);
    end
    send_bits(mk(8'h08, 1'b0, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("after_timeout", rc0, 8'h08, 2'b00);
  endtask

  task automatic test_read_enable();
    int rc0;
    rc0 = ready_cnt;
    bif.READ_ENABLE = 1'b0;
    send_bits(mk(8'hFF, 1'b1, 1'b1, 1'b0), 0, 10, 1'b0);
    checks++;
    if (ready_cnt !== rc0) begin
      errors++;
      $display("FAIL re_low: got %0d strobes, required 0", ready_cnt - rc0);
    end
    send_bits(mk(8'hFF, 1'b1, 1'b1, 1'b0), 0, 2, 1'b0);
    bif.READ_ENABLE = 1'b1;
    send_bits(mk(8'hFF, 1'b1, 1'b1, 1'b0), 3, 10, 1'b0);
    checks++;
    if (ready_cnt !== rc0) begin
      errors++;
      $display("FAIL re_mid: got %0d strobes, required 0", ready_cnt - rc0);
    end
    send_bits(mk(8'hFF, 1'b1, 1'b1, 1'b1), 0, 10, 1'b0);
    checks++;
    if (ready_cnt !== rc0 || bif.BYTE_READ !== 8'h08) begin
      errors++;
      $display("FAIL bad_start: got %0d strobes byte=%02h, required 0 strobes byte=08",
               ready_cnt - rc0, bif.BYTE_READ);
    end
  endtask

  task automatic test_glitch();
    int rc0;
    rc0 = ready_cnt;
    send_bits(mk(8'hF4, 1'b0, 1'b1, 1'b0), 0, 10, 1'b1);
    expect_byte("glitch", rc0, 8'hF4, 2'b00);
  endtask

  task automatic test_reset_midframe();
    int rc0;
    rc0 = ready_cnt;
    send_bits(mk(8'h03, 1'b1, 1'b1, 1'b0), 0, 5, 1'b0);
    RESET = 1'b1;
    wait_cycles(2);
    RESET = 1'b0;
    wait_cycles(1);
    check_outputs_zero("mid_reset_outputs");
    checks++;
    if (ready_cnt !== rc0) begin
      errors++;
      $display("FAIL mid_reset_ready: got %0d strobes, required 0", ready_cnt - rc0);
    end
    wait_cycles(HALF);
    send_bits(mk(8'h03, 1'b1, 1'b1, 1'b0), 0, 10, 1'b0);
    expect_byte("after_mid_reset", rc0, 8'h03, 2'b00);
  endtask

  initial begin
    RESET             = 1'b1;
    bif.CLK_MOUSE_IN  = 1'b1;
    bif.DATA_MOUSE_IN = 1'b1;
    bif.READ_ENABLE   = 1'b1;
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_read_enable();
    test_glitch();
    test_reset_midframe();
    wait_cycles(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
